// File: rtl/qam_symbol_packer.sv
// Serialises DATA_W-bit words into SYM_W-bit symbols on a fixed SYM_PERIOD-clock slot grid.
// Build option: define QAM_PACK_LSB_FIRST_EN for LSB-first symbol order (default MSB-first).
module qam_symbol_packer #(
  parameter int DATA_W     = 8,
  parameter int SYM_W      = 2,
  parameter int SYM_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic [SYM_W-1:0]  signal_out,
  output logic              select,
  output logic              busy,
  output logic              underrun
);

  localparam int NSYM  = DATA_W / SYM_W;
  localparam int CNT_W = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
  localparam int REM_W = $clog2(NSYM + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_PERIOD - 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(NSYM);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [SYM_W-1:0]  sym_q, sym_d;
  logic              sel_q, sel_d;
  logic              ur_q, ur_d;
  logic              act_q, act_d;
  logic              busy_q, busy_d;

  logic              tick;
  logic              load;
  logic              emit;
  logic [SYM_W-1:0]  head_sym;
  logic [DATA_W-1:0] sr_shifted;

`ifdef QAM_PACK_LSB_FIRST_EN
  assign head_sym   = sr_q[SYM_W-1:0];
  assign sr_shifted = sr_q >> SYM_W;
`else
  assign head_sym   = sr_q[DATA_W-1 -: SYM_W];
  assign sr_shifted = sr_q << SYM_W;
`endif

  assign tick       = (cnt_q == CNT_LAST);
  assign data_ready = (rem_q == '0) || ((rem_q == REM_ONE) && tick);
  assign load       = data_valid && data_ready;
  assign emit       = tick && (rem_q != '0);

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    rem_d  = rem_q;
    sr_d   = sr_q;
    sym_d  = sym_q;
    sel_d  = 1'b0;
    ur_d   = 1'b0;
    act_d  = act_q;

    if (emit) begin
      sym_d = head_sym;
      sel_d = 1'b1;
      sr_d  = sr_shifted;
      rem_d = rem_q - REM_ONE;
      act_d = 1'b1;
    end else if (tick && act_q) begin
      // slot came round with nothing queued after a stream had started
      ur_d  = 1'b1;
      act_d = 1'b0;
    end

    // a new word overrides the shift so the final symbol and the load share an edge
    if (load) begin
      sr_d  = data_in;
      rem_d = REM_FULL;
    end

    busy_d = (rem_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      sr_q   <= '0;
      sym_q  <= '0;
      sel_q  <= 1'b0;
      ur_q   <= 1'b0;
      act_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      sr_q   <= sr_d;
      sym_q  <= sym_d;
      sel_q  <= sel_d;
      ur_q   <= ur_d;
      act_q  <= act_d;
      busy_q <= busy_d;
    end
  end

  assign signal_out = sym_q;
  assign select     = sel_q;
  assign underrun   = ur_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_qam_symbol_packer.sv
// Directed bench for qam_symbol_packer: one instance at SYM_PERIOD=4, one at SYM_PERIOD=1.
// Honours QAM_PACK_LSB_FIRST_EN for the expected symbol order.
module tb_qam_symbol_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] d4_data, d1_data;
  logic       d4_valid, d1_valid;
  logic       d4_ready, d1_ready;
  logic [1:0] d4_sym, d1_sym;
  logic       d4_sel, d1_sel, d4_busy, d1_busy, d4_ur, d1_ur;

  qam_symbol_packer #(.DATA_W(8), .SYM_W(2), .SYM_PERIOD(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(d4_data), .data_valid(d4_valid),
    .data_ready(d4_ready), .signal_out(d4_sym), .select(d4_sel),
    .busy(d4_busy), .underrun(d4_ur));

  qam_symbol_packer #(.DATA_W(8), .SYM_W(2), .SYM_PERIOD(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(d1_data), .data_valid(d1_valid),
    .data_ready(d1_ready), .signal_out(d1_sym), .select(d1_sel),
    .busy(d1_busy), .underrun(d1_ur));

  int checks = 0;
  int failures = 0;

  // index of non-reset edges since the last reset edge
  int ecnt = 0;
  always @(posedge clk) begin
    if (!rst) ecnt <= 0;
    else      ecnt <= ecnt + 1;
  end

  int s4_val[$], s4_edge[$], u4_edge[$];
  int s1_val[$], s1_edge[$], u1_edge[$];

  always @(negedge clk) begin
    if (d4_sel === 1'b1) begin s4_val.push_back(int'(d4_sym)); s4_edge.push_back(ecnt - 1); end
    if (d4_ur  === 1'b1) u4_edge.push_back(ecnt - 1);
    if (d1_sel === 1'b1) begin s1_val.push_back(int'(d1_sym)); s1_edge.push_back(ecnt - 1); end
    if (d1_ur  === 1'b1) u1_edge.push_back(ecnt - 1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    s4_val.delete(); s4_edge.delete(); u4_edge.delete();
    s1_val.delete(); s1_edge.delete(); u1_edge.delete();
  endtask

  function automatic int nt4(input int e);
    int x;
    x = e + 1;
    while (x % 4 != 3) x++;
    return x;
  endfunction

  function automatic int sym_at(input int first_syms[4], input int k);
`ifdef QAM_PACK_LSB_FIRST_EN
    return first_syms[3 - k];
`else
    return first_syms[k];
`endif
  endfunction

  task automatic send4(input logic [7:0] w, output int ld_edge);
    d4_data  = w;
    d4_valid = 1'b1;
    ld_edge  = -1;
    for (int i = 0; i < 100; i++) begin
      if (d4_ready) begin
        step();
        ld_edge = ecnt - 1;
        break;
      end
      step();
    end
    d4_valid = 1'b0;
    if (ld_edge < 0) check("send4_ready_timeout", 0, 1);
  endtask

  task automatic wait_ur4(input int budget);
    int n;
    n = 0;
    while (u4_edge.size() == 0 && n < budget) begin step(); n++; end
    if (u4_edge.size() == 0) check("ur4_timeout", 0, 1);
  endtask

  // Symbols listed in MSB-first order; LSB-first build reverses them.
  typedef struct {
    logic [7:0] w;
    int e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int ld, l0, l1, bad, n;
    int ex[4];
    int ld_edges[$];
    logic [7:0] sb[$];
    logic [7:0] got;

    vecs[0] = '{8'hB4, 2, 3, 1, 0};
    vecs[1] = '{8'h1B, 0, 1, 2, 3};
    vecs[2] = '{8'hE4, 3, 2, 1, 0};
    vecs[3] = '{8'h55, 1, 1, 1, 1};
    vecs[4] = '{8'hFF, 3, 3, 3, 3};
    vecs[5] = '{8'h00, 0, 0, 0, 0};
    vecs[6] = '{8'h9C, 2, 1, 3, 0};
    vecs[7] = '{8'h63, 1, 2, 0, 3};

    // reset held with valid data pending
    rst = 1'b0;
    d4_valid = 1'b1; d4_data = 8'hFF;
    d1_valid = 1'b1; d1_data = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_select",   d4_sel,  0);
      check("rst_sym",      d4_sym,  0);
      check("rst_busy",     d4_busy, 0);
      check("rst_underrun", d4_ur,   0);
    end
    rst = 1'b1;
    d4_valid = 1'b0;
    d1_valid = 1'b0;
    step();
    check("post_rst_busy4", d4_busy, 0);
    check("post_rst_busy1", d1_busy, 0);
    for (int i = 0; i < 8; i++) step();
    check("post_rst_no_strobe", s4_val.size() + s1_val.size(), 0);
    check("post_rst_no_ur",     u4_edge.size() + u1_edge.size(), 0);

    // single words, varied slot phase, SYM_PERIOD=4
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < v % 4; i++) step();
      clear_logs();
      ex[0] = vecs[v].e0; ex[1] = vecs[v].e1; ex[2] = vecs[v].e2; ex[3] = vecs[v].e3;
      send4(vecs[v].w, ld);
      wait_ur4(60);
      check("word_strobes", s4_val.size(), 4);
      if (s4_val.size() == 4) begin
        for (int k = 0; k < 4; k++) begin
          check("word_sym",  s4_val[k],  sym_at(ex, k));
          check("word_edge", s4_edge[k], nt4(ld) + 4 * k);
        end
        check("word_ur_count", u4_edge.size(), 1);
        if (u4_edge.size() >= 1) check("word_ur_edge", u4_edge[0], s4_edge[3] + 4);
        check("word_hold_sym", d4_sym, sym_at(ex, 3));
      end
      check("word_busy_idle", d4_busy, 0);
    end

    // back-to-back at SYM_PERIOD=1 with valid held
    clear_logs();
    l0 = -1; l1 = -1;
    d1_data = 8'h1B; d1_valid = 1'b1;
    for (int i = 0; i < 20 && l0 < 0; i++) begin
      if (d1_ready) begin step(); l0 = ecnt - 1; end
      else step();
    end
    d1_data = 8'hE4;
    for (int i = 0; i < 20 && l1 < 0; i++) begin
      if (d1_ready) begin step(); l1 = ecnt - 1; end
      else step();
    end
    d1_valid = 1'b0;
    check("b2b_loads_seen", (l0 >= 0 && l1 >= 0) ? 1 : 0, 1);
    check("b2b_second_load_edge", l1 - l0, 4);
    for (int i = 0; i < 15; i++) step();
    check("b2b_strobes", s1_val.size(), 8);
    if (s1_val.size() == 8) begin
      ex = '{0, 1, 2, 3};
      for (int k = 0; k < 4; k++) check("b2b_sym_w0", s1_val[k], sym_at(ex, k));
      ex = '{3, 2, 1, 0};
      for (int k = 0; k < 4; k++) check("b2b_sym_w1", s1_val[4 + k], sym_at(ex, k));
      bad = 0;
      for (int k = 0; k < 8; k++) if (s1_edge[k] != l0 + 1 + k) bad++;
      check("b2b_consecutive", bad, 0);
    end
    check("b2b_ur_count", u1_edge.size(), 1);
    if (u1_edge.size() >= 1) check("b2b_ur_after_stream", u1_edge[0], l0 + 9);

    // backpressure with 100 random bytes, valid held throughout
    clear_logs();
    d4_valid = 1'b1;
    d4_data  = 8'($urandom_range(0, 255));
    for (int w = 0; w < 100; w++) begin
      ld = -1;
      for (int i = 0; i < 40 && ld < 0; i++) begin
        if (d4_ready) begin
          step();
          ld = ecnt - 1;
          sb.push_back(d4_data);
          ld_edges.push_back(ld);
          d4_data = 8'($urandom_range(0, 255));
        end else begin
          step();
        end
      end
      if (ld < 0) begin
        check("bp_ready_timeout", 0, 1);
        break;
      end
    end
    d4_valid = 1'b0;
    wait_ur4(200);
    check("bp_transfers", ld_edges.size(), 100);
    bad = 0;
    if (ld_edges.size() >= 2 && ld_edges[1] != nt4(ld_edges[0]) + 12) bad++;
    for (int w = 2; w < ld_edges.size(); w++) if (ld_edges[w] != ld_edges[w-1] + 16) bad++;
    check("bp_spacing", bad, 0);
    check("bp_symbols", s4_val.size(), 400);
    n = (s4_val.size() / 4 < sb.size()) ? s4_val.size() / 4 : sb.size();
    bad = 0;
    for (int w = 0; w < n; w++) begin
`ifdef QAM_PACK_LSB_FIRST_EN
      got = {s4_val[4*w+3][1:0], s4_val[4*w+2][1:0], s4_val[4*w+1][1:0], s4_val[4*w][1:0]};
`else
      got = {s4_val[4*w][1:0], s4_val[4*w+1][1:0], s4_val[4*w+2][1:0], s4_val[4*w+3][1:0]};
`endif
      if (got != sb[w]) bad++;
    end
    check("bp_word_mismatches", bad, 0);
    check("bp_ur_count", u4_edge.size(), 1);
    if (u4_edge.size() >= 1 && s4_val.size() > 0)
      check("bp_ur_edge", u4_edge[0], s4_edge[s4_edge.size()-1] + 4);

    // reset in the middle of a word
    clear_logs();
    send4(8'hB4, ld);
    n = 0;
    while (s4_val.size() < 2 && n < 40) begin step(); n++; end
    check("mid_two_syms", s4_val.size(), 2);
    rst = 1'b0;
    step();
    step();
    check("mid_rst_select", d4_sel,  0);
    check("mid_rst_busy",   d4_busy, 0);
    check("mid_rst_sym",    d4_sym,  0);
    rst = 1'b1;
    clear_logs();
    for (int i = 0; i < 20; i++) step();
    check("mid_no_leftover", s4_val.size(), 0);
    check("mid_no_ur",       u4_edge.size(), 0);
    send4(8'h55, ld);
    wait_ur4(60);
    check("mid_new_strobes", s4_val.size(), 4);
    if (s4_val.size() == 4)
      for (int k = 0; k < 4; k++) check("mid_new_sym", s4_val[k], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d expected=0", $time);
    $fatal(1, "timeout");
  end

endmodule
